// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, drives it to the instruction memory and
// captures the returned word into the IF/ID register. Stall, flush and branch
// redirection are resolved here with priority reset > branch > flush > stall > advance.
// Optional performance counters are enabled by defining FETCH_PERF_COUNTERS_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic        if_id_valid
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifp4_q, ifp4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  // Mutually exclusive per-edge actions, already resolved by priority.
  logic do_branch, do_flush, do_hold, do_adv;

  assign pc_plus4  = pc_q + 32'd4;
  assign do_branch = branch_taken;
  assign do_flush  = !branch_taken && flush;
  assign do_hold   = !branch_taken && !flush && stall;
  assign do_adv    = !branch_taken && !flush && !stall;

  // Next-state selection for the PC and the IF/ID register.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    ifp4_d  = ifp4_q;
    valid_d = valid_q;
    if (do_branch || do_flush) begin
      // Squash IF/ID to a bubble.
      instr_d = NOP_INSTR;
      ifpc_d  = 32'd0;
      ifp4_d  = 32'd0;
      valid_d = 1'b0;
    end
    if (do_branch) begin
      // Low two target bits are dropped to keep the PC word aligned.
      pc_d = branch_target & 32'hFFFF_FFFC;
    end else if (do_flush) begin
      pc_d = stall ? pc_q : pc_plus4;
    end else if (do_adv) begin
      pc_d    = pc_plus4;
      instr_d = imem_instruction;
      ifpc_d  = pc_q;
      ifp4_d  = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // PC and IF/ID state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 32'd0;
      ifp4_q  <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      ifp4_q  <= ifp4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_address      = pc_q;
  assign if_id_instruction = instr_q;
  assign if_id_pc          = ifpc_q;
  assign if_id_pc_plus4    = ifp4_q;
  assign if_id_valid       = valid_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  // Count valid IF/ID loads and stall-hold edges; both wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if (do_adv)  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (do_hold) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a directed table of the main scenarios
// followed by randomized control traffic checked against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, flush, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_address, imem_instruction;
  logic [31:0] if_id_instruction, if_id_pc, if_id_pc_plus4;
  logic        if_id_valid;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count, stall_count;
`endif

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed hash of the address.
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0001;
  endfunction

  assign imem_instruction = im_word(imem_address);

  fetch_stage #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .flush            (flush),
    .branch_taken     (branch_taken),
    .branch_target    (branch_target),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .if_id_instruction(if_id_instruction),
    .if_id_pc         (if_id_pc),
    .if_id_pc_plus4   (if_id_pc_plus4),
    .if_id_valid      (if_id_valid)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetch_count      (fetch_count),
    .stall_count      (stall_count)
`endif
  );

  // Behavioural model state.
  logic [31:0] m_pc, m_ins, m_ipc, m_ip4, m_fc, m_sc;
  logic        m_valid;

  task automatic model_edge(input logic r, s, f, b, input logic [31:0] t);
    logic [31:0] old_pc;
    old_pc = m_pc;
    if (r) begin
      m_pc = RST_PC; m_ins = NOP; m_ipc = 0; m_ip4 = 0; m_valid = 0; m_fc = 0; m_sc = 0;
    end else if (b || f) begin
      m_ins = NOP; m_ipc = 0; m_ip4 = 0; m_valid = 0;
      if (b) m_pc = {t[31:2], 2'b00};
      else if (!s) m_pc = old_pc + 4;
    end else if (s) begin
      m_sc = m_sc + 1;
    end else begin
      m_ins = im_word(old_pc); m_ipc = old_pc; m_ip4 = old_pc + 4; m_valid = 1;
      m_pc = old_pc + 4; m_fc = m_fc + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " imem_address"}, imem_address, m_pc);
    chk({tag, " if_id_instruction"}, if_id_instruction, m_ins);
    chk({tag, " if_id_pc"}, if_id_pc, m_ipc);
    chk({tag, " if_id_pc_plus4"}, if_id_pc_plus4, m_ip4);
    chk({tag, " if_id_valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_COUNTERS_EN
    chk({tag, " fetch_count"}, fetch_count, m_fc);
    chk({tag, " stall_count"}, stall_count, m_sc);
`endif
  endtask

  // Apply controls, take one edge, advance the model and sample 1 time unit later.
  task automatic cycle(input logic r, s, f, b, input logic [31:0] t);
    reset = r; stall = s; flush = f; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_edge(r, s, f, b, t);
    #1;
  endtask

  typedef struct {
    logic        r, s, f, b;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic        e_valid;
  } vec_t;

  vec_t vecs[20];
  logic [31:0] e_ins, e_p4;

  initial begin
    reset = 1; stall = 0; flush = 0; branch_taken = 0; branch_target = 0;
    //          r  s  f  b  target          addr            if_id_pc        valid
    vecs[0]  = '{1, 0, 0, 0, 32'h0,          32'h0,          32'h0,          0};
    vecs[1]  = '{0, 0, 0, 0, 32'h0,          32'h4,          32'h0,          1};
    vecs[2]  = '{0, 0, 0, 0, 32'h0,          32'h8,          32'h4,          1};
    vecs[3]  = '{0, 1, 0, 0, 32'h0,          32'h8,          32'h4,          1};
    vecs[4]  = '{0, 1, 0, 0, 32'h0,          32'h8,          32'h4,          1};
    vecs[5]  = '{0, 1, 0, 0, 32'h0,          32'h8,          32'h4,          1};
    vecs[6]  = '{0, 0, 0, 0, 32'h0,          32'hC,          32'h8,          1};
    vecs[7]  = '{0, 0, 0, 0, 32'h0,          32'h10,         32'hC,          1};
    vecs[8]  = '{0, 0, 0, 1, 32'h43,         32'h40,         32'h0,          0};
    vecs[9]  = '{0, 0, 0, 0, 32'h0,          32'h44,         32'h40,         1};
    vecs[10] = '{0, 1, 1, 0, 32'h0,          32'h44,         32'h0,          0};
    vecs[11] = '{0, 0, 0, 0, 32'h0,          32'h48,         32'h44,         1};
    vecs[12] = '{0, 1, 1, 1, 32'hFFFF_FFFE,  32'hFFFF_FFFC,  32'h0,          0};
    vecs[13] = '{0, 0, 0, 0, 32'h0,          32'h0,          32'hFFFF_FFFC,  1};
    vecs[14] = '{0, 0, 0, 0, 32'h0,          32'h4,          32'h0,          1};
    vecs[15] = '{0, 0, 0, 1, 32'h14,         32'h14,         32'h0,          0};
    vecs[16] = '{0, 0, 0, 0, 32'h0,          32'h18,         32'h14,         1};
    vecs[17] = '{1, 1, 1, 1, 32'h100,        32'h0,          32'h0,          0};
    vecs[18] = '{0, 0, 0, 0, 32'h0,          32'h4,          32'h0,          1};
    vecs[19] = '{0, 0, 1, 0, 32'h0,          32'h8,          32'h0,          0};

    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].b, vecs[i].tgt);
      e_ins = vecs[i].e_valid ? im_word(vecs[i].e_pc) : NOP;
      e_p4  = vecs[i].e_valid ? vecs[i].e_pc + 32'd4 : 32'd0;
      chk($sformatf("vec%0d addr", i), imem_address, vecs[i].e_addr);
      chk($sformatf("vec%0d pc", i), if_id_pc, vecs[i].e_pc);
      chk($sformatf("vec%0d valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("vec%0d instr", i), if_id_instruction, e_ins);
      chk($sformatf("vec%0d pc_plus4", i), if_id_pc_plus4, e_p4);
      check_model($sformatf("vec%0d model", i));
`ifdef FETCH_PERF_COUNTERS_EN
      if (i == 5) chk("stall_count after 3 stalls", stall_count, 32'd3);
      if (i == 17) chk("fetch_count after reset", fetch_count, 32'd0);
`endif
    end

    // Randomized control traffic, targets occasionally near the wrap point.
    for (int i = 0; i < 600; i++) begin
      logic        r, s, f, b;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 25);
      f = ($urandom_range(0, 99) < 10);
      b = ($urandom_range(0, 99) < 10);
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | $urandom_range(0, 15) : $urandom;
      cycle(r, s, f, b, t);
      check_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
